mdu_hilo: RTL

- Execute-stage multiply/divide unit and HI/LO register file.
- Consumes the 5-bit alucontrol codes produced by the ALU decoder and acts on these ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Multiply completes in one cycle. Divide is an iterative radix-2 restoring operation that stalls the pipeline.
- Supplies HI/LO read data for MFHI/MFLO to the E-stage result mux.

---
 rtl/mdu_hilo_pkg.sv | 28 ++
 rtl/mdu_hilo_div_radix2.sv | 101 ++++++++++
 rtl/mdu_hilo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo shared definitions: ALU control codes, divider FSM states
// and a small two's-complement helper used by the sign fix-up logic.
package mdu_hilo_pkg;

    // Control codes emitted by the ALU decoder for HI/LO ops.
    localparam logic [4:0] MULT_CONTROL  = 5'b10000;
    localparam logic [4:0] MULTU_CONTROL = 5'b10001;
    localparam logic [4:0] DIV_CONTROL   = 5'b10010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
    localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
    localparam logic [4:0] MTLO_CONTROL  = 5'b10101;
    localparam logic [4:0] MFHI_CONTROL  = 5'b10110;
    localparam logic [4:0] MFLO_CONTROL  = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] neg_if(
        input logic        neg,
        input logic [31:0] val
    );
        return neg ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/mdu_hilo_div_radix2.sv
// div_radix2: 32-cycle radix-2 restoring divider on unsigned magnitudes.
// Ports: clk, rst (sync, active-high); start_i/skip_i/abort_i control;
//   dvd_i/dvs_i operands; idle_o/busy_o/done_o status;
//   quo_o/rem_o results, valid while done_o is high.
// skip_i jumps IDLE->DONE on start (used for fast divide-by-zero).
module div_radix2
    import mdu_hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              skip_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] dvd_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic              idle_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quo_o,
    output logic [DATA_W-1:0] rem_o
);

    div_state_e        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;

    // Shifted partial remainder needs one extra bit; the trial
    // difference only matters when it is non-negative, where it
    // always fits back into DATA_W bits.
    logic [DATA_W:0]   rem_sh;
    logic              ge;
    logic [DATA_W-1:0] diff;

    assign rem_sh = {rem_q, quo_q[DATA_W-1]};
    assign ge     = rem_sh >= {1'b0, dvs_q};
    assign diff   = rem_sh[DATA_W-1:0] - dvs_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    quo_d   = dvd_i;
                    rem_d   = '0;
                    dvs_d   = dvs_i;
                    cnt_d   = '0;
                    state_d = skip_i ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    quo_d = {quo_q[DATA_W-2:0], ge};
                    rem_d = ge ? diff : rem_sh[DATA_W-1:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
        end
    end

    assign idle_o = (state_q == IDLE);
    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit with HI/LO registers.
// Ports: clk, rst (sync, active-high); e_valid, alucontrol_e,
//   srca_e, srcb_e, flush_e from E; hilo_rdata to the result mux;
//   mdu_stall freezes IF/ID/E; hi_o/lo_o expose HI/LO.
// Macro MDU_DIV_ZERO_FAST_EN: divide by zero skips the 32-cycle run.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e_valid,
    input  logic [4:0]        alucontrol_e,
    input  logic [DATA_W-1:0] srca_e,
    input  logic [DATA_W-1:0] srcb_e,
    input  logic              flush_e,
    output logic [DATA_W-1:0] hilo_rdata,
    output logic              mdu_stall,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] dz_hi_q, dz_hi_d;

    logic is_mult, is_multu, is_mul;
    logic is_div, is_divu, is_dv;
    logic is_mthi, is_mtlo;

    assign is_mult  = (alucontrol_e == MULT_CONTROL);
    assign is_multu = (alucontrol_e == MULTU_CONTROL);
    assign is_div   = (alucontrol_e == DIV_CONTROL);
    assign is_divu  = (alucontrol_e == DIVU_CONTROL);
    assign is_mthi  = (alucontrol_e == MTHI_CONTROL);
    assign is_mtlo  = (alucontrol_e == MTLO_CONTROL);
    assign is_mul   = is_mult | is_multu;
    assign is_dv    = is_div | is_divu;

    logic div_idle, div_busy, div_done;
    logic fire, start, skip;

    assign fire  = e_valid & ~flush_e & div_idle;
    assign start = fire & is_dv;

    // Single 64x64 multiplier; operands are sign- or zero-extended
    // so the low 64 bits give the signed or unsigned product.
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;

    assign ext_a = {{DATA_W{is_mult & srca_e[DATA_W-1]}}, srca_e};
    assign ext_b = {{DATA_W{is_mult & srcb_e[DATA_W-1]}}, srcb_e};
    assign prod  = ext_a * ext_b;

    // Signed divide works on magnitudes; the most negative value
    // maps onto itself, which is the right unsigned magnitude.
    logic              sa, sb, dvs_zero;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W-1:0] quo, rem;

    assign sa       = is_div & srca_e[DATA_W-1];
    assign sb       = is_div & srcb_e[DATA_W-1];
    assign mag_a    = neg_if(sa, srca_e);
    assign mag_b    = neg_if(sb, srcb_e);
    assign dvs_zero = (srcb_e == '0);

`ifdef MDU_DIV_ZERO_FAST_EN
    assign skip = dvs_zero;
`else
    assign skip = 1'b0;
`endif

    div_radix2 #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .skip_i  (skip),
        .abort_i (flush_e),
        .dvd_i   (mag_a),
        .dvs_i   (mag_b),
        .idle_o  (div_idle),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (quo),
        .rem_o   (rem)
    );

    // DONE leaves stall low so the held DIV can retire from E.
    assign mdu_stall = start | (div_busy & ~flush_e);

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        dz_hi_d   = dz_hi_q;
        if (start) begin
            neg_quo_d = sa ^ sb;
            neg_rem_d = sa;
            dz_d      = dvs_zero;
            dz_hi_d   = srca_e;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (fire) begin
            unique case (1'b1)
                is_mul: begin
                    hi_d = prod[2*DATA_W-1:DATA_W];
                    lo_d = prod[DATA_W-1:0];
                end
                is_mthi: hi_d = srca_e;
                is_mtlo: lo_d = srca_e;
                default: ;
            endcase
        end else if (div_done & ~flush_e) begin
            if (dz_q) begin
                lo_d = '1;
                hi_d = dz_hi_q;
            end else begin
                lo_d = neg_if(neg_quo_q, quo);
                hi_d = neg_if(neg_rem_q, rem);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            dz_hi_q   <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            dz_hi_q   <= dz_hi_d;
        end
    end

    always_comb begin
        hilo_rdata = '0;
        unique case (1'b1)
            alucontrol_e == MFHI_CONTROL: hilo_rdata = hi_q;
            alucontrol_e == MFLO_CONTROL: hilo_rdata = lo_q;
            default: ;
        endcase
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
